// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: default width and FSM state encoding.
package count_seq_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/count_seq_ctrl_counter.sv
// Count datapath: registered up-counter with synchronous reset, clear and enable.
// Clear takes priority over enable.
module up_counter_en #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Count register: reset/clear to zero, otherwise increment modulo 2^WIDTH when enabled.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// Count sequence controller: one-shot or periodic count from 0 to a latched limit,
// with pause, abort and registered busy/done/wrap status.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t           state;
  logic [WIDTH-1:0] lim_r;
  logic             mode_r;
  logic             at_lim;
  logic             clr;
  logic             en;

  up_counter_en #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .en   (en),
    .q    (q)
  );

  // Counter control: clear on abort, on an accepted start and on a periodic wrap;
  // advance only while running, unpaused and below the limit.
  always_comb begin
    at_lim = (q == lim_r);
    clr    = 1'b0;
    en     = 1'b0;
    if (stop) begin
      clr = 1'b1;
    end else begin
      case (state)
        IDLE: clr = start;
        RUN: begin
          if (!pause) begin
            if (at_lim) clr = mode_r;
            else        en  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      lim_r  <= '0;
      mode_r <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      wrap   <= 1'b0;
    end else if (stop) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lim_r  <= limit;
            mode_r <= mode;
            if (limit == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!pause && at_lim) begin
            if (mode_r) begin
              wrap <= 1'b1;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Self-checking bench for count_seq_ctrl: vector table, directed corner sequences,
// and randomized stimulus against a tick-counting reference model.
module tb_count_seq_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset, start, stop, pause, mode;
  logic [W-1:0] limit;
  logic [W-1:0] q;
  logic         busy, done, wrap;

  int unsigned total  = 0;
  int unsigned passed = 0;

  // Reference model: counts effective (unpaused) cycles since start and derives
  // q from that count arithmetically.
  bit m_busy = 0, m_done = 0, m_wrap = 0, m_per = 0;
  int m_q = 0, m_lim = 0, m_ticks = 0;

  typedef struct {
    bit       r, s, st, p, md;
    int       l;
    int       eq;
    bit       eb, ed, ew;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  count_seq_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .stop (stop),
    .pause(pause),
    .mode (mode),
    .limit(limit),
    .q    (q),
    .busy (busy),
    .done (done),
    .wrap (wrap)
  );

  function automatic void model_edge();
    if (reset) begin
      m_busy = 0; m_done = 0; m_wrap = 0; m_per = 0;
      m_q = 0; m_lim = 0; m_ticks = 0;
    end else if (stop) begin
      m_busy = 0; m_done = 0; m_wrap = 0; m_q = 0;
    end else begin
      m_wrap = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_busy) begin
        if (!pause) begin
          m_ticks++;
          if (!m_per && m_ticks > m_lim) begin
            m_busy = 0; m_done = 1; m_q = m_lim;
          end else begin
            m_q    = m_ticks % (m_lim + 1);
            m_wrap = m_per && (m_q == 0);
          end
        end
      end else if (start) begin
        m_lim = int'(limit); m_per = mode; m_ticks = 0; m_q = 0;
        if (limit == 0) m_done = 1;
        else            m_busy = 1;
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input int eq, input bit eb, input bit ed, input bit ew);
    check({tag, ".q"},    int'(q),    eq);
    check({tag, ".busy"}, int'(busy), int'(eb));
    check({tag, ".done"}, int'(done), int'(ed));
    check({tag, ".wrap"}, int'(wrap), int'(ew));
  endtask

  task automatic drive(input bit r, input bit s, input bit st, input bit p, input bit md, input int l);
    reset = r; start = s; stop = st; pause = p; mode = md; limit = W'(l);
  endtask

  // One clock edge; model advances with the same inputs; outputs settle 1 time unit later.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic void row(bit r, bit s, bit st, bit p, bit md, int l, int eq, bit eb, bit ed, bit ew);
    tbl.push_back('{r: r, s: s, st: st, p: p, md: md, l: l, eq: eq, eb: eb, ed: ed, ew: ew});
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0);

    //  r  s  st p  md lim   q  b  d  w
    row(1, 0, 0, 0, 0, 0,    0, 0, 0, 0);  // reset
    row(0, 0, 0, 0, 0, 0,    0, 0, 0, 0);  // idle
    row(0, 1, 1, 0, 0, 5,    0, 0, 0, 0);  // stop beats start
    row(0, 1, 0, 0, 0, 4,    0, 1, 0, 0);  // one-shot limit 4
    row(0, 0, 0, 0, 1, 9,    1, 1, 0, 0);  // limit/mode change ignored
    row(0, 1, 0, 0, 0, 9,    2, 1, 0, 0);  // start ignored in RUN
    row(0, 0, 0, 0, 0, 0,    3, 1, 0, 0);
    row(0, 0, 0, 0, 0, 0,    4, 1, 0, 0);
    row(0, 0, 0, 0, 0, 0,    4, 0, 1, 0);  // done, busy falls
    row(0, 1, 0, 0, 0, 3,    4, 0, 0, 0);  // start ignored in DONE, q holds
    row(0, 0, 0, 1, 0, 0,    4, 0, 0, 0);  // pause ignored in IDLE
    row(0, 1, 0, 0, 0, 0,    0, 0, 1, 0);  // limit 0 -> DONE directly
    row(0, 0, 0, 0, 0, 0,    0, 0, 0, 0);
    row(0, 1, 0, 0, 1, 2,    0, 1, 0, 0);  // periodic limit 2
    row(0, 0, 0, 0, 0, 0,    1, 1, 0, 0);
    row(0, 0, 0, 0, 0, 0,    2, 1, 0, 0);
    row(0, 0, 0, 0, 0, 0,    0, 1, 0, 1);  // wrap
    row(0, 0, 0, 1, 0, 0,    0, 1, 0, 0);  // pause after wrap
    row(0, 0, 0, 0, 0, 0,    1, 1, 0, 0);
    row(0, 0, 0, 0, 0, 0,    2, 1, 0, 0);
    row(0, 0, 0, 0, 0, 0,    0, 1, 0, 1);
    row(0, 1, 1, 1, 0, 7,    0, 0, 0, 0);  // stop over start and pause

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].st, tbl[i].p, tbl[i].md, tbl[i].l);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].eq, tbl[i].eb, tbl[i].ed, tbl[i].ew);
    end

    // Reset held 3 cycles mid-run at q=5, start asserted throughout.
    drive(0, 1, 0, 0, 0, 10); tick();
    drive(0, 0, 0, 0, 0, 10);
    for (int i = 0; i < 5; i++) tick();
    check("rst_mid.q_pre", int'(q), 5);
    drive(1, 1, 0, 0, 0, 10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("rst_mid%0d", i), 0, 0, 0, 0);
    end
    drive(0, 1, 0, 0, 0, 3); tick();
    chk_out("first_start", 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 0); tick();

    // One-shot limit 6 paused 3 cycles at q=3: done 10 edges after the start edge.
    begin
      int n = 0;
      drive(0, 1, 0, 0, 0, 6); tick();
      drive(0, 0, 0, 0, 0, 6);
      for (int i = 0; i < 3; i++) begin tick(); n++; end
      check("pause.q_at", int'(q), 3);
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick(); n++;
        chk_out($sformatf("pause_hold%0d", i), 3, 1, 0, 0);
      end
      pause = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin tick(); n++; end
      check("pause.done_edge", n, 10);
      check("pause.q_final", int'(q), 6);
      tick();
    end

    // Abort at q=7 of limit 10: no done pulse follows.
    drive(0, 1, 0, 0, 0, 10); tick();
    drive(0, 0, 0, 0, 0, 10);
    for (int i = 0; i < 7; i++) tick();
    check("abort.q_pre", int'(q), 7);
    stop = 1'b1; tick();
    chk_out("abort", 0, 0, 0, 0);
    stop = 1'b0; tick();
    chk_out("abort_after", 0, 0, 0, 0);

    // Limit 0 then full-range one-shot 0..15, done on the 17th edge.
    drive(0, 1, 0, 0, 0, 0); tick();
    chk_out("lim0", 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 15); tick();
    chk_out("full0", 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("full.q%0d", i), int'(q), i);
    end
    tick();
    chk_out("full_done", 15, 0, 1, 0);
    tick();
    chk_out("full_idle", 15, 0, 0, 0);

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 150) == 0;
      stop  = ($urandom % 60) == 0;
      start = ($urandom % 6) == 0;
      pause = ($urandom % 4) == 0;
      mode  = 1'($urandom % 2);
      limit = (($urandom % 3) == 0) ? W'($urandom % 16) : W'($urandom % 5);
      tick();
      chk_out($sformatf("rnd%0d", i), m_q, m_busy, m_done, m_wrap);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
